// File: rtl/exec_unit_pipe_pkg.sv
// Shared encodings and default sizing for the execution unit pipeline.
package exec_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } unit_st_e;

    localparam int DEF_DATA_W     = 64;
    localparam int DEF_ID_W       = 3;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_ADD_LAT    = 1;
    localparam int DEF_MUL_LAT    = 3;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/exec_unit_pipe_req_fifo.sv
// Request queue: power-of-two circular buffer; the caller never pushes when full or pops when empty.
module req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/exec_unit_pipe.sv
// In-order issue queue feeding an add unit and a mul unit; completed results leave through a round-robin response port.
module exec_unit_pipe
    import exec_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ID_W       = DEF_ID_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ADD_LAT    = DEF_ADD_LAT,
    parameter int MUL_LAT    = DEF_MUL_LAT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_op,
    input  logic [ID_W-1:0]               req_id,
    input  logic [DATA_W-1:0]             req_data1,
    input  logic [DATA_W-1:0]             req_data2,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = 2 + ID_W + 2 * DATA_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic              push, pop;
    logic [EW-1:0]     head;
    op_e               h_op;
    logic [ID_W-1:0]   h_id;
    logic [DATA_W-1:0] h_a, h_b, add_res, mul_res;
    logic              head_vld, disp_add, disp_mul;

    unit_st_e          add_st_q, mul_st_q;
    logic [CNT_W-1:0]  add_cnt_q, mul_cnt_q;
    logic [ID_W-1:0]   add_id_q, mul_id_q;
    logic [DATA_W-1:0] add_data_q, mul_data_q;
    logic              add_err_q;

    logic              add_done, mul_done, sel_mul, hs;
    logic              lock_q, lock_mul_q, rr_q;

    assign req_ready = (fifo_count < DEPTH_C);
    assign push      = req_valid && req_ready;

    req_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({req_op, req_id, req_data1, req_data2}),
        .rdata_o (head),
        .count_o (fifo_count)
    );

    assign h_op     = op_e'(head[EW-1 -: 2]);
    assign h_id     = head[2*DATA_W +: ID_W];
    assign h_a      = head[DATA_W +: DATA_W];
    assign h_b      = head[0 +: DATA_W];
    assign head_vld = (fifo_count != '0);

    // Head-of-line issue: a blocked head stalls every younger entry.
    assign disp_add = head_vld && (h_op != OP_MUL) && (add_st_q == ST_IDLE);
    assign disp_mul = head_vld && (h_op == OP_MUL) && (mul_st_q == ST_IDLE);
    assign pop      = disp_add || disp_mul;

    always_comb begin
        add_res = '0;
        case (h_op)
            OP_ADD:  add_res = h_a + h_b;
            OP_SUB:  add_res = h_a - h_b;
            default: add_res = '0;
        endcase
    end

    assign mul_res = h_a * h_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_st_q  <= ST_IDLE;
            add_cnt_q <= '0;
        end else begin
            case (add_st_q)
                ST_IDLE: if (disp_add) begin
                    add_st_q  <= ST_BUSY;
                    add_cnt_q <= CNT_W'(ADD_LAT - 1);
                end
                ST_BUSY: if (add_cnt_q == '0) add_st_q <= ST_DONE;
                         else                 add_cnt_q <= add_cnt_q - 1'b1;
                ST_DONE: if (hs && !sel_mul) add_st_q <= ST_IDLE;
                default: add_st_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_st_q  <= ST_IDLE;
            mul_cnt_q <= '0;
        end else begin
            case (mul_st_q)
                ST_IDLE: if (disp_mul) begin
                    mul_st_q  <= ST_BUSY;
                    mul_cnt_q <= CNT_W'(MUL_LAT - 1);
                end
                ST_BUSY: if (mul_cnt_q == '0) mul_st_q <= ST_DONE;
                         else                 mul_cnt_q <= mul_cnt_q - 1'b1;
                ST_DONE: if (hs && sel_mul) mul_st_q <= ST_IDLE;
                default: mul_st_q <= ST_IDLE;
            endcase
        end
    end

    // Results are captured at dispatch; the counters only model latency.
    always_ff @(posedge clk) begin
        if (disp_add) begin
            add_id_q   <= h_id;
            add_data_q <= add_res;
            add_err_q  <= (h_op == OP_RSVD);
        end
        if (disp_mul) begin
            mul_id_q   <= h_id;
            mul_data_q <= mul_res;
        end
    end

    assign add_done  = (add_st_q == ST_DONE);
    assign mul_done  = (mul_st_q == ST_DONE);
    assign rsp_valid = add_done || mul_done;
    assign hs        = rsp_valid && rsp_ready;

    always_comb begin
        sel_mul = mul_done;
        if (lock_q)                    sel_mul = lock_mul_q;
        else if (add_done && mul_done) sel_mul = rr_q;
    end

    // A stalled grant is locked so the offered response cannot switch units.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_mul_q <= 1'b0;
            rr_q       <= 1'b0;
        end else if (hs) begin
            lock_q <= 1'b0;
            rr_q   <= !sel_mul;
        end else if (rsp_valid) begin
            lock_q     <= 1'b1;
            lock_mul_q <= sel_mul;
        end
    end

    assign rsp_id   = !rsp_valid ? '0 : (sel_mul ? mul_id_q : add_id_q);
    assign rsp_data = !rsp_valid ? '0 : (sel_mul ? mul_data_q : add_data_q);
    assign rsp_err  = rsp_valid && !sel_mul && add_err_q;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Directed bench for exec_unit_pipe: single-op vector table plus ordering, backpressure, arbitration and reset sequences.
module tb_exec_unit_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_id;
    logic [63:0] req_data1, req_data2;
    logic        rsp_valid, rsp_ready;
    logic [2:0]  rsp_id;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    logic [2:0]  got_id   [16];
    logic [63:0] got_data [16];
    int          got_n;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  id;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [8];

    exec_unit_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_id     (req_id),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] id,
                        input logic [63:0] a, input logic [63:0] b);
        int w = 0;
        req_op = op; req_id = id; req_data1 = a; req_data2 = b;
        req_valid = 1'b1;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) chk("send_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic collect(input int n, input int max_cyc);
        int cyc = 0;
        got_n = 0;
        while (got_n < n && cyc < max_cyc) begin
            if (rsp_valid && rsp_ready) begin
                got_id[got_n]   = rsp_id;
                got_data[got_n] = rsp_data;
                got_n++;
            end
            tick();
            cyc++;
        end
        chk("collect_count", 64'(got_n), 64'(n));
    endtask

    initial begin
        int n, acc, cyc, stale;
        logic taken;

        vecs[0] = '{2'd0, 3'd1, 64'd5, 64'd7, 64'd12, 1'b0, 2};
        vecs[1] = '{2'd1, 3'd2, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2};
        vecs[2] = '{2'd2, 3'd3, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 1'b0, 4};
        vecs[3] = '{2'd2, 3'd4, 64'd3, 64'd5, 64'd15, 1'b0, 4};
        vecs[4] = '{2'd3, 3'd5, 64'd9, 64'd9, 64'd0, 1'b1, 2};
        vecs[5] = '{2'd0, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 2};
        vecs[6] = '{2'd2, 3'd7, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 4};
        vecs[7] = '{2'd1, 3'd0, 64'd10, 64'd3, 64'd7, 1'b0, 2};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_id = '0;
        req_data1 = '0; req_data2 = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].op, vecs[i].id, vecs[i].a, vecs[i].b);
            n = 0;
            while (!rsp_valid && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(n), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_id", i), 64'(rsp_id), 64'(vecs[i].id));
            chk($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp);
            chk($sformatf("vec%0d_err", i), 64'(rsp_err), 64'(vecs[i].err));
            tick();
            chk($sformatf("vec%0d_idle_zero", i), 64'({rsp_valid, rsp_err}) | rsp_data, 64'd0);
        end

        // Younger ADD overtakes an older MUL in flight.
        send(2'd2, 3'd2, 64'd6, 64'd7);
        send(2'd0, 3'd3, 64'd1, 64'd1);
        collect(2, 30);
        chk("order_first", 64'(got_id[0]), 64'd3);
        chk("order_second", 64'(got_id[1]), 64'd2);
        chk("order_mul_data", got_data[1], 64'd42);

        // Second MUL blocks the ADD behind it until it dispatches.
        send(2'd2, 3'd4, 64'd2, 64'd2);
        send(2'd2, 3'd5, 64'd3, 64'd3);
        send(2'd0, 3'd6, 64'd1, 64'd2);
        collect(3, 40);
        chk("hol_first", 64'(got_id[0]), 64'd4);
        chk("hol_second", 64'(got_id[1]), 64'd6);
        chk("hol_third", 64'(got_id[2]), 64'd5);

        // Backpressure: fill the queue behind a held response.
        rsp_ready = 1'b0;
        acc = 0; cyc = 0;
        req_op = 2'd0; req_data2 = '0;
        while (acc < 5 && cyc < 40) begin
            req_id = acc[2:0];
            req_data1 = 64'(100 + acc);
            req_valid = 1'b1;
            taken = req_ready;
            tick();
            if (taken) acc++;
            cyc++;
        end
        req_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd5);
        chk("bp_fifo_count", 64'(fifo_count), 64'd4);
        chk("bp_req_ready", 64'(req_ready), 64'd0);
        req_id = 3'd5; req_data1 = 64'd105; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_ready", 64'(req_ready), 64'd0);
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_id", 64'(rsp_id), 64'd0);
            chk("bp_hold_data", rsp_data, 64'd100);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        collect(5, 60);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_rsp%0d_id", k), 64'(got_id[k]), 64'(k));
            chk($sformatf("bp_rsp%0d_data", k), got_data[k], 64'(100 + k));
        end

        // Round-robin: both units finish on the same edge.
        rst = 1'b1; #2; rst = 1'b0;
        tick();
        send(2'd2, 3'd1, 64'd2, 64'd3);
        tick();
        send(2'd0, 3'd2, 64'd4, 64'd5);
        collect(2, 30);
        chk("rr1_first", 64'(got_id[0]), 64'd2);
        chk("rr1_second", 64'(got_id[1]), 64'd1);
        send(2'd2, 3'd3, 64'd2, 64'd3);
        tick();
        send(2'd0, 3'd4, 64'd4, 64'd5);
        collect(2, 30);
        chk("rr2_first", 64'(got_id[0]), 64'd4);
        chk("rr2_second", 64'(got_id[1]), 64'd3);
        send(2'd0, 3'd5, 64'd1, 64'd1);
        collect(1, 20);
        chk("rr_lone_add", 64'(got_id[0]), 64'd5);
        send(2'd2, 3'd6, 64'd2, 64'd3);
        tick();
        send(2'd0, 3'd7, 64'd4, 64'd5);
        collect(2, 30);
        chk("rr3_first", 64'(got_id[0]), 64'd6);
        chk("rr3_second", 64'(got_id[1]), 64'd7);

        // Reset with one op held in the add unit and three queued.
        rsp_ready = 1'b0;
        send(2'd0, 3'd1, 64'd1, 64'd1);
        send(2'd0, 3'd2, 64'd2, 64'd2);
        send(2'd0, 3'd3, 64'd3, 64'd3);
        send(2'd0, 3'd4, 64'd4, 64'd4);
        chk("mid_fifo_count", 64'(fifo_count), 64'd3);
        tick();
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_count", 64'(fifo_count), 64'd0);
        chk("async_rst_data", rsp_data, 64'd0);
        chk("async_rst_id", 64'(rsp_id), 64'd0);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        stale = 0;
        repeat (12) begin
            if (rsp_valid) stale++;
            tick();
        end
        chk("no_stale_rsp", 64'(stale), 64'd0);
        send(2'd3, 3'd6, 64'hDEAD, 64'hBEEF);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rsvd_latency", 64'(n), 64'd2);
        chk("rsvd_err", 64'(rsp_err), 64'd1);
        chk("rsvd_data", rsp_data, 64'd0);
        chk("rsvd_id", 64'(rsp_id), 64'd6);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
